dmux_src: RTL and testbench
===========================

DMUX_SRC -- requirements
Module: dmux_src

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  32  data word width
  SYNC_STAGES  2  ack synchronizer depth, legal 2..4
  MODE  0  0 = four-phase level handshake, 1 = two-phase toggle handshake
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_a  in  1  source clock; the only clock
  rst_n_a  in  1  asynchronous active-low reset
  in_vld  in  1  upstream word valid
  in_data  in  WIDTH  upstream word
  in_rdy  out  1  upstream ready; a word is accepted on a clk_a edge where in_vld && in_rdy
  ack_in  in  1  acknowledge from destination domain, asynchronous to clk_a
  req_out  out  1  request to destination, registered
  data_out  out  WIDTH  launched word, registered, held stable while a transfer is in flight
  busy  out  1  state != IDLE or pending word held
  done  out  1  one-cycle pulse per completed transfer
  xfer_cnt  out  16  completed-transfer count
REQ-003 Clock and reset SHALL be one clock, clk_a, and reset rst_n_a, asynchronous and active-low.

Function
REQ-004 ack_in SHALL pass through SYNC_STAGES flops on clk_a before use; the synchronized value is ack_s; ack_in SHALL have no other path into logic.
REQ-005 A one-entry pending register SHALL hold accepted words; in_rdy = !pend_vld || launch_now.
REQ-006 FSM states SHALL be IDLE, REQ and ACK_LOW; ACK_LOW is used only when MODE=0.
REQ-007 launch_now SHALL be true when state=IDLE, pend_vld=1 and ack_s==req_out; launch loads data_out from the pending register, clears pend_vld, updates req_out, and enters REQ, all on the same edge.
REQ-008 MODE=0: launch SHALL set req_out=1; in REQ with ack_s=1, req_out<=0 and the FSM goes to ACK_LOW; in ACK_LOW with ack_s=0, the FSM goes to IDLE and done is pulsed.
REQ-009 MODE=1: launch SHALL toggle req_out; in REQ with ack_s==req_out, the FSM goes to IDLE and done is pulsed.
REQ-010 data_out SHALL change only on a launch edge, never while req_out awaits acknowledge.
REQ-011 Accept on edge N with IDLE and matching ack SHALL give req_out change at edge N+1 (latency 1 cycle from pending to launch).
REQ-012 Simultaneous launch and accept SHALL move the pending word out and the new word in on the same edge, with no loss or duplication.
REQ-013 in_vld with in_rdy=0 SHALL be ignored, and in_data is not sampled.
REQ-014 xfer_cnt SHALL increment on each done and wrap from 16'hFFFF to 0.
REQ-015 A stale ack_s mismatch in IDLE (ack_in still asserted after reset) SHALL block launch until ack_s==req_out; no spurious done is produced.

Reset
REQ-016 rst_n_a low SHALL asynchronously clear: state=IDLE, req_out=0, data_out=0, pend_vld=0, done=0, xfer_cnt=0, and all sync flops=0; in_rdy=1 after release.
REQ-017 Reset mid-transfer SHALL drop the in-flight and pending words; they are not retransmitted.

Structure
REQ-018 dmux_pkg SHALL hold the FSM state typedef (IDLE/REQ/ACK_LOW), the MODE_LEVEL=0 and MODE_TOGGLE=1 constants, and the xfer_cnt width constant 16.
REQ-019 The ack synchronizer SHALL be a sub-module sync_ff (parameter STAGES), shared with the destination side.

Verification
REQ-020 MODE=0, SYNC_STAGES=2, 32'hA5A5_0001 accepted at edge 0, ack_in raised 3 cycles after req_out and dropped 3 cycles after req_out falls -> req_out rises at edge 1, data_out=32'hA5A5_0001 stable until next launch, done pulses once, and xfer_cnt=1.
REQ-021 MODE=1, three back-to-back words 1,2,3 with in_vld held high and ack_in a delayed copy of req_out -> req_out toggles 3 times, data_out sequence is 1,2,3, and xfer_cnt=3.
REQ-022 in_vld held with ack_in stuck low -> one launch, the second word held pending, in_rdy=0 after the second accept, busy=1, and done never asserts.
REQ-023 rst_n_a asserted while in REQ with ack_in=1, then released -> all outputs zero; a new word is not launched until ack_s=0 (MODE=0), and there is no done pulse.
REQ-024 xfer_cnt preset by running 65536 transfers (MODE=1, ack_in = delayed req_out) -> xfer_cnt wraps to 0.
REQ-025 Random ack_in delay 0..7 cycles, 1000 words -> scoreboard shows output order equals input order, with no loss or duplicate.

Source files
------------

// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared types and constants for the source-side handshake
package dmux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } state_t;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;
    localparam int CNT_W       = 16;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - single-bit multi-flop synchronizer, cleared by reset
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/dmux_src.sv
// rtl/dmux_src.sv - source side of a req/ack word crossing with a one-entry pending buffer
module dmux_src
    import dmux_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic             clk_a,
    input  logic             rst_n_a,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    input  logic             ack_in,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic               ack_s;
    logic               req_nxt;
    logic               done_nxt;
    logic               launch_now;
    logic               accept;
    logic               pend_vld;
    logic [WIDTH-1:0]   pend_data;

    sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_a),
        .rst_n (rst_n_a),
        .d     (ack_in),
        .q     (ack_s)
    );

    // A stale ack after reset leaves ack_s != req_out, which holds off launch.
    assign launch_now = (state == IDLE) && pend_vld && (ack_s == req_out);
    assign in_rdy     = !pend_vld || launch_now;
    assign accept     = in_vld && in_rdy;
    assign busy       = (state != IDLE) || pend_vld;

    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = req_out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (launch_now) begin
                    state_nxt = REQ;
                    req_nxt   = (MODE == MODE_TOGGLE) ? !req_out : 1'b1;
                end
            end
            REQ: begin
                if (MODE == MODE_TOGGLE) begin
                    if (ack_s == req_out) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ACK_LOW;
                end
            end
            ACK_LOW: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            req_out   <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            xfer_cnt  <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
        end else begin
            req_out <= req_nxt;
            done    <= done_nxt;
            if (done_nxt) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (launch_now) begin
                data_out <= pend_data;
            end
            // Accept wins over the clear so a same-edge launch+accept keeps the new word.
            if (accept) begin
                pend_data <= in_data;
                pend_vld  <= 1'b1;
            end else if (launch_now) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmux_src.sv
// tb/tb_dmux_src.sv - randomized self-checking bench for dmux_src in both handshake modes
module tb_dmux_src;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vld0, rdy0, ack0, req0, busy0, done0;
    logic         vld1, rdy1, ack1, req1, busy1, done1;
    logic [W-1:0] din0, dout0, din1, dout1;
    logic [15:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    dmux_src #(.WIDTH(W), .SYNC_STAGES(2), .MODE(0)) dut0 (
        .clk_a(clk), .rst_n_a(rst_n), .in_vld(vld0), .in_data(din0), .in_rdy(rdy0),
        .ack_in(ack0), .req_out(req0), .data_out(dout0), .busy(busy0), .done(done0),
        .xfer_cnt(cnt0)
    );

    dmux_src #(.WIDTH(W), .SYNC_STAGES(2), .MODE(1)) dut1 (
        .clk_a(clk), .rst_n_a(rst_n), .in_vld(vld1), .in_data(din1), .in_rdy(rdy1),
        .ack_in(ack1), .req_out(req1), .data_out(dout1), .busy(busy1), .done(done1),
        .xfer_cnt(cnt1)
    );

    int compared   = 0;
    int mismatched = 0;

    // destination model: ack follows req after a random number of cycles, or a manual level
    bit auto0 = 0, auto1 = 0, man0 = 0, man1 = 0;
    int lo0 = 0, hi0 = 0, lo1 = 0, hi1 = 0;

    initial begin : ack_drv0
        int w;
        w = -1;
        ack0 = 1'b0;
        forever begin
            @(negedge clk);
            if (!auto0) begin
                ack0 = man0;
                w = -1;
            end else if (ack0 !== req0) begin
                if (w < 0) w = int'($urandom_range(hi0, lo0));
                if (w == 0) begin ack0 = req0; w = -1; end
                else w--;
            end
        end
    end

    initial begin : ack_drv1
        int w;
        w = -1;
        ack1 = 1'b0;
        forever begin
            @(negedge clk);
            if (!auto1) begin
                ack1 = man1;
                w = -1;
            end else if (ack1 !== req1) begin
                if (w < 0) w = int'($urandom_range(hi1, lo1));
                if (w == 0) begin ack1 = req1; w = -1; end
                else w--;
            end
        end
    end

    // observation: launched words, done pulses, count at each done, data changes without launch
    logic [W-1:0] lau0[$], lau1[$], sent0[$], sent1[$];
    logic [15:0]  cq0[$], cq1[$];
    int           dones0 = 0, dones1 = 0, viol0 = 0, viol1 = 0;
    logic         pr0, pr1;
    logic [W-1:0] pd0, pd1;

    initial forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
            pr0 = 1'b0; pd0 = '0;
        end else begin
            if (req0 && !pr0) lau0.push_back(dout0);
            if (dout0 !== pd0 && req0 === pr0) viol0++;
            if (done0) begin dones0++; cq0.push_back(cnt0); end
            pr0 = req0; pd0 = dout0;
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
            pr1 = 1'b0; pd1 = '0;
        end else begin
            if (req1 !== pr1) lau1.push_back(dout1);
            if (dout1 !== pd1 && req1 === pr1) viol1++;
            if (done1) begin dones1++; cq1.push_back(cnt1); end
            pr1 = req1; pd1 = dout1;
        end
    end

    logic [15:0] exp_cnt0 = 16'h0, exp_cnt1 = 16'h0;

    task automatic push(input int sel, input logic [W-1:0] w);
        int b;
        b = 0;
        if (sel == 0) begin vld0 = 1'b1; din0 = w; sent0.push_back(w); end
        else          begin vld1 = 1'b1; din1 = w; sent1.push_back(w); end
        while (((sel == 0) ? rdy0 : rdy1) !== 1'b1 && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) begin
            compared++; mismatched++;
            $display("FAIL push_timeout sel=%0d word=%h got rdy=0 exp rdy=1", sel, w);
        end
        @(negedge clk);
    endtask

    task automatic wait_dones(input int sel, input int target, input int limit);
        int b;
        b = 0;
        while (((sel == 0) ? dones0 : dones1) < target && b < limit) begin
            @(negedge clk);
            b++;
        end
        compared++;
        if (b >= limit) begin
            mismatched++;
            $display("FAIL wait_done sel=%0d got=%0d exp=%0d", sel, (sel == 0) ? dones0 : dones1, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld0 = 0; vld1 = 0; din0 = '0; din1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({req0, dout0, busy0, done0, cnt0, rdy0} !== {1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_m0 got req=%b data=%h busy=%b done=%b cnt=%h rdy=%b exp 0/0/0/0/0/1",
                     req0, dout0, busy0, done0, cnt0, rdy0);
        end
        compared++;
        if ({req1, dout1, busy1, done1, cnt1, rdy1} !== {1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_m1 got req=%b data=%h busy=%b done=%b cnt=%h rdy=%b exp 0/0/0/0/0/1",
                     req1, dout1, busy1, done1, cnt1, rdy1);
        end
    endtask

    task automatic test_level_single();
        int base;
        lo0 = 3; hi0 = 3; auto0 = 1;
        lau0.delete(); base = dones0;
        vld0 = 1'b1; din0 = 32'hA5A5_0001;
        compared++;
        if (rdy0 !== 1'b1) begin mismatched++; $display("FAIL lvl_rdy got=%b exp=1", rdy0); end
        @(negedge clk);
        vld0 = 1'b0;
        compared++;
        if ({req0, busy0} !== 2'b01) begin
            mismatched++; $display("FAIL lvl_edge0 got req=%b busy=%b exp req=0 busy=1", req0, busy0);
        end
        @(negedge clk);
        compared++;
        if (req0 !== 1'b1 || dout0 !== 32'hA5A5_0001) begin
            mismatched++; $display("FAIL lvl_edge1 got req=%b data=%h exp req=1 data=a5a50001", req0, dout0);
        end
        wait_dones(0, base + 1, 100);
        repeat (10) @(negedge clk);
        exp_cnt0 = exp_cnt0 + 16'd1;
        compared++;
        if (dones0 - base != 1 || cnt0 !== exp_cnt0) begin
            mismatched++; $display("FAIL lvl_done got dones=%0d cnt=%h exp dones=1 cnt=%h", dones0 - base, cnt0, exp_cnt0);
        end
        compared++;
        if (lau0.size() != 1 || dout0 !== 32'hA5A5_0001 || busy0 !== 1'b0 || req0 !== 1'b0) begin
            mismatched++;
            $display("FAIL lvl_final got launches=%0d data=%h busy=%b req=%b exp 1/a5a50001/0/0",
                     lau0.size(), dout0, busy0, req0);
        end
    endtask

    task automatic test_toggle_b2b();
        int base;
        lo1 = 1; hi1 = 1; auto1 = 1;
        lau1.delete(); sent1.delete(); base = dones1;
        push(1, 32'd1);
        push(1, 32'd2);
        push(1, 32'd3);
        vld1 = 1'b0;
        wait_dones(1, base + 3, 200);
        exp_cnt1 = exp_cnt1 + 16'd3;
        compared++;
        if (lau1.size() != 3) begin
            mismatched++; $display("FAIL b2b_toggles got=%0d exp=3", lau1.size());
        end else begin
            compared++;
            if ({lau1[0], lau1[1], lau1[2]} !== {32'd1, 32'd2, 32'd3}) begin
                mismatched++; $display("FAIL b2b_order got=%h,%h,%h exp=1,2,3", lau1[0], lau1[1], lau1[2]);
            end
        end
        compared++;
        if (cnt1 !== exp_cnt1 || dones1 - base != 3) begin
            mismatched++; $display("FAIL b2b_cnt got cnt=%h dones=%0d exp cnt=%h dones=3", cnt1, dones1 - base, exp_cnt1);
        end
    endtask

    task automatic test_stuck_ack();
        int base;
        logic [W-1:0] w1, w2;
        man0 = 1'b0; auto0 = 0;
        repeat (4) @(negedge clk);
        lau0.delete(); base = dones0;
        w1 = $urandom; w2 = $urandom;
        push(0, w1);
        push(0, w2);
        vld0 = 1'b1; din0 = $urandom;
        repeat (20) @(negedge clk);
        compared++;
        if ({rdy0, busy0, req0} !== 3'b011 || dones0 != base) begin
            mismatched++;
            $display("FAIL stuck_state got rdy=%b busy=%b req=%b dones=%0d exp rdy=0 busy=1 req=1 dones=%0d",
                     rdy0, busy0, req0, dones0, base);
        end
        compared++;
        if (lau0.size() != 1 || dout0 !== w1) begin
            mismatched++; $display("FAIL stuck_launch got launches=%0d data=%h exp 1/%h", lau0.size(), dout0, w1);
        end
        vld0 = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int base, b;
        logic [W-1:0] w3;
        man0 = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({req0, dout0, busy0, done0, cnt0, rdy0} !== {1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            mismatched++;
            $display("FAIL midrst_async got req=%b data=%h busy=%b done=%b cnt=%h rdy=%b exp 0/0/0/0/0/1",
                     req0, dout0, busy0, done0, cnt0, rdy0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt0 = 16'h0; exp_cnt1 = 16'h0;
        lau0.delete(); base = dones0;
        repeat (4) @(negedge clk);
        w3 = $urandom;
        push(0, w3);
        vld0 = 1'b0;
        repeat (10) @(negedge clk);
        compared++;
        if (req0 !== 1'b0 || busy0 !== 1'b1 || lau0.size() != 0 || dones0 != base) begin
            mismatched++;
            $display("FAIL midrst_block got req=%b busy=%b launches=%0d dones=%0d exp req=0 busy=1 launches=0 dones=%0d",
                     req0, busy0, lau0.size(), dones0, base);
        end
        man0 = 1'b0;
        b = 0;
        while (req0 !== 1'b1 && b < 20) begin @(negedge clk); b++; end
        compared++;
        if (req0 !== 1'b1 || dout0 !== w3) begin
            mismatched++; $display("FAIL midrst_launch got req=%b data=%h exp req=1 data=%h", req0, dout0, w3);
        end
        lo0 = 0; hi0 = 0; auto0 = 1;
        wait_dones(0, base + 1, 100);
        exp_cnt0 = exp_cnt0 + 16'd1;
        compared++;
        if (cnt0 !== exp_cnt0 || lau0.size() != 1 || dones0 - base != 1) begin
            mismatched++;
            $display("FAIL midrst_after got cnt=%h launches=%0d dones=%0d exp cnt=%h launches=1 dones=1",
                     cnt0, lau0.size(), dones0 - base, exp_cnt0);
        end
    endtask

    task automatic test_wrap();
        int base;
        @(negedge clk);
        force dut1.xfer_cnt = 16'hFFFE;
        @(negedge clk);
        release dut1.xfer_cnt;
        exp_cnt1 = 16'hFFFE;
        cq1.delete(); base = dones1;
        lo1 = 0; hi1 = 2; auto1 = 1;
        push(1, $urandom);
        push(1, $urandom);
        push(1, $urandom);
        vld1 = 1'b0;
        wait_dones(1, base + 3, 200);
        exp_cnt1 = exp_cnt1 + 16'd3;
        compared++;
        if (cq1.size() != 3) begin
            mismatched++; $display("FAIL wrap_dones got=%0d exp=3", cq1.size());
        end else begin
            compared++;
            if ({cq1[0], cq1[1], cq1[2]} !== {16'hFFFF, 16'h0000, 16'h0001}) begin
                mismatched++; $display("FAIL wrap_seq got=%h,%h,%h exp=ffff,0000,0001", cq1[0], cq1[1], cq1[2]);
            end
        end
        compared++;
        if (cnt1 !== exp_cnt1) begin mismatched++; $display("FAIL wrap_cnt got=%h exp=%h", cnt1, exp_cnt1); end
    endtask

    task automatic test_random();
        int b0, b1, bad0, bad1;
        lau0.delete(); lau1.delete(); sent0.delete(); sent1.delete();
        b0 = dones0; b1 = dones1;
        lo0 = 0; hi0 = 7; auto0 = 1;
        lo1 = 0; hi1 = 7; auto1 = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(3, 0) == 0) begin
                        vld0 = 1'b0;
                        repeat ($urandom_range(3, 1)) @(negedge clk);
                    end
                    push(0, $urandom);
                end
                vld0 = 1'b0;
            end
            begin
                for (int j = 0; j < 1000; j++) begin
                    if ($urandom_range(3, 0) == 0) begin
                        vld1 = 1'b0;
                        repeat ($urandom_range(3, 1)) @(negedge clk);
                    end
                    push(1, $urandom);
                end
                vld1 = 1'b0;
            end
        join
        wait_dones(0, b0 + 300, 20000);
        wait_dones(1, b1 + 1000, 20000);
        repeat (20) @(negedge clk);
        exp_cnt0 = exp_cnt0 + 16'd300;
        exp_cnt1 = exp_cnt1 + 16'd1000;
        bad0 = 0; bad1 = 0;
        compared++;
        if (lau0.size() != sent0.size() || dones0 - b0 != 300) begin
            mismatched++; $display("FAIL rnd_m0_count got launches=%0d dones=%0d exp %0d/300", lau0.size(), dones0 - b0, sent0.size());
        end else begin
            for (int i = 0; i < lau0.size(); i++) if (lau0[i] !== sent0[i]) bad0++;
            compared++;
            if (bad0 != 0) begin mismatched++; $display("FAIL rnd_m0_order got bad=%0d exp=0", bad0); end
        end
        compared++;
        if (lau1.size() != sent1.size() || dones1 - b1 != 1000) begin
            mismatched++; $display("FAIL rnd_m1_count got launches=%0d dones=%0d exp %0d/1000", lau1.size(), dones1 - b1, sent1.size());
        end else begin
            for (int i = 0; i < lau1.size(); i++) if (lau1[i] !== sent1[i]) bad1++;
            compared++;
            if (bad1 != 0) begin mismatched++; $display("FAIL rnd_m1_order got bad=%0d exp=0", bad1); end
        end
        compared++;
        if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin
            mismatched++; $display("FAIL rnd_cnt got %h/%h exp %h/%h", cnt0, cnt1, exp_cnt0, exp_cnt1);
        end
        compared++;
        if (viol0 != 0 || viol1 != 0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            mismatched++;
            $display("FAIL data_stable got viol=%0d/%0d busy=%b/%b exp 0/0 0/0", viol0, viol1, busy0, busy1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vld0 = 0; vld1 = 0; din0 = '0; din1 = '0;
        test_reset();
        test_level_single();
        test_toggle_b2b();
        test_stuck_ack();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
